// File: rtl/i2c_flash_programmer.sv
// Purpose: I2C master that turns one command into one 8-byte write (device address, 3 flash-address bytes, 4 data bytes).
// Latency: done or nack_err shows 296*CLK_DIV+1 cycles after the accept cycle on success, and (4+(k+1)*36+4)*CLK_DIV+1 on a NACK of byte k.
// Backpressure: cmd_ready drops after accept and returns in the FIN cycle; cmd inputs are ignored while busy.

module i2c_flash_programmer #(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        nack_err,
  output logic [2:0]  nack_byte,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int            CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_FIN
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick;
  logic          accept;
  logic [1:0]    q_q;
  logic [2:0]    bit_q;
  logic [2:0]    byte_q;
  logic [63:0]   sh_q;
  logic          err_q;
  logic          scl_oe_q;
  logic          sda_oe_q;
  logic          rdy_q;
  logic          busy_q;
  logic          done_q;
  logic          nack_q;
  logic [2:0]    nack_byte_q;

  assign accept = cmd_valid & rdy_q;
  assign tick   = (cnt_q == CNT_MAX);

  // Quarter-bit divider: next value wraps at CLK_DIV-1, producing one tick per wrap
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Divider register: realigned on every accept so the first tick lands CLK_DIV cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Transfer FSM: every line and status output is registered and changes only on a tick or on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      q_q         <= 2'd0;
      bit_q       <= 3'd0;
      byte_q      <= 3'd0;
      sh_q        <= 64'd0;
      err_q       <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rdy_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      nack_byte_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      nack_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            sh_q        <= {DEV_ADDR, 1'b0, cmd_addr, cmd_data};
            state_q     <= S_START;
            q_q         <= 2'd0;
            bit_q       <= 3'd0;
            byte_q      <= 3'd0;
            err_q       <= 1'b0;
            nack_byte_q <= 3'd0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b1;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            q_q <= q_q + 2'd1;
            case (q_q)
              2'd1: sda_oe_q <= 1'b1;   // SDA falls while SCL is high: START
              2'd2: scl_oe_q <= 1'b1;
              2'd3: begin
                state_q  <= S_BIT;
                scl_oe_q <= 1'b1;
                sda_oe_q <= ~sh_q[63];
              end
              default: ;
            endcase
          end
        end
        S_BIT: begin
          if (tick) begin
            q_q <= q_q + 2'd1;
            case (q_q)
              2'd1: scl_oe_q <= 1'b0;
              2'd3: begin
                // Shift after every bit so the next byte's MSB is at [63] on entry to ACK
                sh_q     <= {sh_q[62:0], 1'b0};
                scl_oe_q <= 1'b1;
                if (bit_q == 3'd7) begin
                  state_q  <= S_ACK;
                  bit_q    <= 3'd0;
                  sda_oe_q <= 1'b0;
                end else begin
                  bit_q    <= bit_q + 3'd1;
                  sda_oe_q <= ~sh_q[62];
                end
              end
              default: ;
            endcase
          end
        end
        S_ACK: begin
          if (tick) begin
            q_q <= q_q + 2'd1;
            case (q_q)
              2'd1: scl_oe_q <= 1'b0;
              2'd3: begin
                scl_oe_q <= 1'b1;
                if (sda_i) begin
                  err_q       <= 1'b1;
                  nack_byte_q <= byte_q;
                  state_q     <= S_STOP;
                  sda_oe_q    <= 1'b1;
                end else if (byte_q == 3'd7) begin
                  state_q  <= S_STOP;
                  sda_oe_q <= 1'b1;
                end else begin
                  byte_q   <= byte_q + 3'd1;
                  state_q  <= S_BIT;
                  sda_oe_q <= ~sh_q[63];
                end
              end
              default: ;
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            q_q <= q_q + 2'd1;
            case (q_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd1: sda_oe_q <= 1'b0;   // SDA rises while SCL is high: STOP
              2'd3: begin
                state_q <= S_FIN;
                done_q  <= ~err_q;
                nack_q  <= err_q;
                rdy_q   <= 1'b1;
                busy_q  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack_err  = nack_q;
  assign nack_byte = nack_byte_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_flash_programmer.sv
// Testbench for i2c_flash_programmer: responder and bus decoder on the open-drain lines,
// vector table of hand-derived results, randomized commands against a byte/latency model.
module tb_i2c_flash_programmer;

  localparam int         DIV = 4;
  localparam logic [6:0] DEV = 7'h50;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        busy;
  logic        done;
  logic        nack_err;
  logic [2:0]  nack_byte;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_i;
  logic        slv_pull = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int nack_at = 8;

  i2c_flash_programmer #(.CLK_DIV(DIV), .DEV_ADDR(DEV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .nack_err  (nack_err),
    .nack_byte (nack_byte),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain pad: low if either side pulls
  assign sda_i = ~(sda_oe | slv_pull);

  // Bus monitor + responder
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         bitcnt = 0;
  int         byteidx = 0;
  logic [7:0] shr = 8'd0;
  logic [7:0] got[$];
  int         n_start = 0;
  int         n_stop  = 0;
  int         n_done  = 0;
  int         n_nack  = 0;

  always @(negedge clk) begin
    logic cs;
    logic cd;
    cs = ~scl_oe;
    cd = sda_i;
    if (done)     n_done <= n_done + 1;
    if (nack_err) n_nack <= n_nack + 1;
    if (rst) begin
      slv_pull <= 1'b0;
      bitcnt   <= 0;
      byteidx  <= 0;
    end else if (p_scl && cs && (p_sda != cd)) begin
      if (!cd) begin
        n_start <= n_start + 1;
        bitcnt  <= 0;
        byteidx <= 0;
      end else begin
        n_stop <= n_stop + 1;
        bitcnt <= 0;
      end
    end else if (!p_scl && cs) begin
      if (bitcnt < 8) begin
        shr <= {shr[6:0], cd};
        if (bitcnt == 7) got.push_back({shr[6:0], cd});
        bitcnt <= bitcnt + 1;
      end else begin
        bitcnt  <= 0;
        byteidx <= byteidx + 1;
      end
    end else if (p_scl && !cs) begin
      slv_pull <= (bitcnt == 8) && (byteidx != nack_at);
    end
    p_scl <= cs;
    p_sda <= cd;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: the 8-byte wire image and the completion latency in cycles
  function automatic logic [7:0] model_byte(input logic [23:0] a, input logic [31:0] d, input int i);
    logic [63:0] img;
    img = {DEV, 1'b0, a, d};
    return img[63 - 8*i -: 8];
  endfunction

  function automatic int model_lat(input int nk);
    int ticks;
    if (nk > 7) ticks = 4 + 8*36 + 4;
    else        ticks = 4 + (nk + 1)*36 + 4;
    return ticks*DIV + 1;
  endfunction

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    int          nk;
    int          lat;
    int          nb;
    logic        dn;
  } vec_t;

  vec_t tv[5];

  task automatic run_cmd(input string tag, input logic [23:0] a, input logic [31:0] d,
                         input int nk, input int lat, input int nb, input logic dn);
    int   acc, s0, t0, g0, dn0, nk0, n_exp;
    logic seen;
    nack_at = nk;
    @(negedge clk);
    #1;
    s0 = n_start; t0 = n_stop; g0 = got.size(); dn0 = n_done; nk0 = n_nack;
    chk({tag, "_ready_before"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; acc = cyc;
    @(negedge clk);
    chk({tag, "_busy_after_accept"}, 64'(busy), 64'(1));
    cmd_valid = 1'b0; cmd_addr = 24'($urandom); cmd_data = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cmd_addr = 24'($urandom); cmd_data = $urandom;
      if (done || nack_err) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_completed"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(cyc - acc), 64'(lat));
    chk({tag, "_done"}, 64'(done), 64'(dn));
    chk({tag, "_nack_err"}, 64'(nack_err), 64'(!dn));
    chk({tag, "_ready_fin"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_busy_fin"}, 64'(busy), 64'(0));
    if (!dn) chk({tag, "_nack_byte"}, 64'(nack_byte), 64'(nb));
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, 64'(done | nack_err), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    if (!dn) chk({tag, "_nack_byte_held"}, 64'(nack_byte), 64'(nb));
    chk({tag, "_done_count"}, 64'(n_done - dn0), 64'(dn ? 1 : 0));
    chk({tag, "_nack_count"}, 64'(n_nack - nk0), 64'(dn ? 0 : 1));
    chk({tag, "_starts"}, 64'(n_start - s0), 64'(1));
    chk({tag, "_stops"}, 64'(n_stop - t0), 64'(1));
    n_exp = (nk > 7) ? 8 : nk + 1;
    chk({tag, "_byte_count"}, 64'(got.size() - g0), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (g0 + i < got.size())
        chk($sformatf("%s_byte%0d", tag, i), 64'(got[g0 + i]), 64'(model_byte(a, d, i)));
    end
  endtask

  initial begin
    int   acc, t1, t2, s0, t0, g0, d0;
    logic seen;
    logic released;
    logic [23:0] a2;
    logic [31:0] d2;

    tv[0] = '{24'h012345, 32'hDEADBEEF, 8, 1185, 0, 1'b1};
    tv[1] = '{24'h012345, 32'hDEADBEEF, 0,  177, 0, 1'b0};
    tv[2] = '{24'hA5A5A5, 32'h12345678, 5,  897, 5, 1'b0};
    tv[3] = '{24'hFFFFFF, 32'h00000000, 8, 1185, 0, 1'b1};
    tv[4] = '{24'h000000, 32'hFFFFFFFF, 7, 1185, 7, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 24'd0; cmd_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_nack", 64'(nack_err), 64'(0));
    chk("rst_nack_byte", 64'(nack_byte), 64'(0));
    chk("rst_scl", 64'(scl_oe), 64'(0));
    chk("rst_sda", 64'(sda_oe), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of byte 1: lines must release immediately, nothing resumes
    nack_at = 8;
    d0 = n_done;
    cmd_valid = 1'b1; cmd_addr = 24'h012345; cmd_data = 32'hDEADBEEF; acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc - acc < 200) @(negedge clk);
    chk("midrst_lines_pulled_before", 64'(scl_oe & sda_oe), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_scl_async", 64'(scl_oe), 64'(0));
    chk("midrst_sda_async", 64'(sda_oe), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    released = 1'b1;
    repeat (1300) begin
      @(negedge clk);
      if (scl_oe || sda_oe || done || nack_err) released = 1'b0;
    end
    chk("midrst_stays_idle", 64'(released), 64'(1));
    chk("midrst_no_done", 64'(n_done - d0), 64'(0));

    for (int i = 0; i < 5; i++)
      run_cmd($sformatf("vec%0d", i), tv[i].addr, tv[i].data, tv[i].nk, tv[i].lat, tv[i].nb, tv[i].dn);

    // Back-to-back: valid held high, second command accepted in the FIN cycle
    nack_at = 8;
    a2 = 24'h7E8001; d2 = 32'hC0FFEE42;
    @(negedge clk);
    #1;
    s0 = n_start; t0 = n_stop; g0 = got.size();
    cmd_valid = 1'b1; cmd_addr = 24'h13579B; cmd_data = 32'h2468ACE0; acc = cyc;
    @(negedge clk);
    cmd_addr = a2; cmd_data = d2;
    seen = 1'b0; t1 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; t1 = cyc; break; end
    end
    chk("b2b_first_done", 64'(seen), 64'(1));
    chk("b2b_first_latency", 64'(t1 - acc), 64'(model_lat(8)));
    chk("b2b_ready_in_fin", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    chk("b2b_second_accepted", 64'(busy), 64'(1));
    cmd_valid = 1'b0; cmd_addr = 24'($urandom); cmd_data = $urandom;
    seen = 1'b0; t2 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; t2 = cyc; break; end
    end
    chk("b2b_second_done", 64'(seen), 64'(1));
    chk("b2b_spacing", 64'(t2 - t1), 64'(model_lat(8)));
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_starts", 64'(n_start - s0), 64'(2));
    chk("b2b_stops", 64'(n_stop - t0), 64'(2));
    chk("b2b_byte_count", 64'(got.size() - g0), 64'(16));
    for (int i = 0; i < 16; i++) begin
      if (g0 + i < got.size()) begin
        if (i < 8) chk($sformatf("b2b_byte%0d", i), 64'(got[g0 + i]), 64'(model_byte(24'h13579B, 32'h2468ACE0, i)));
        else       chk($sformatf("b2b_byte%0d", i), 64'(got[g0 + i]), 64'(model_byte(a2, d2, i - 8)));
      end
    end

    // Randomized commands and NACK positions against the model
    for (int r = 0; r < 6; r++) begin
      logic [23:0] ra;
      logic [31:0] rd;
      int          nk;
      ra = 24'($urandom);
      rd = $urandom;
      nk = int'($urandom_range(0, 11));
      if (nk > 7) nk = 8;
      run_cmd($sformatf("rnd%0d", r), ra, rd, nk, model_lat(nk), (nk > 7) ? 0 : nk, (nk > 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_flash_programmer.md
Name: i2c_flash_programmer

Overview:
- I2C master (transmitter) that drives the I2C flash-loader port of the flash controller.
- Each accepted command is serialised as one I2C write: a device-address byte, three flash-address bytes, then four data bytes.
- Used on bring-up/test boards and by the boot ROM sequencer to program flash over the two-wire link.
- Open-drain signalling: the block only pulls lines low or releases them.

Parameters:
- CLK_DIV, 4: clk cycles per quarter-bit tick; legal range >= 2.
- DEV_ADDR, 7'h50: 7-bit I2C target address; R/W bit is always 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command can be accepted
- cmd_addr  in  24  flash byte address, sent MSB first
- cmd_data  in  32  flash data word, sent MSB first
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse: all 8 bytes ACKed and STOP sent
- nack_err  out  1  one-cycle pulse: transaction aborted on NACK
- nack_byte  out  3  index 0..7 of the NACKed byte; valid with nack_err, held until the next accept
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_i  in  1  sampled SDA pad level

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, done=0, nack_err=0, nack_byte=0, state IDLE.
  - Any partial transfer is dropped; no STOP is generated.
- Accept: cmd_valid && cmd_ready at a rising edge.
  - cmd_addr and cmd_data are latched into an 8-byte shift image: {DEV_ADDR,1'b0}, addr[23:16], addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0].
  - Next cycle: cmd_ready=0, busy=1. Inputs are ignored while busy.
- Tick generator:
  - Counter 0..CLK_DIV-1, cleared on accept; one tick per wrap.
  - Phase counter q = 0..3 advances on each tick.
- States: IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> FIN -> IDLE.
- START (4 ticks):
  - q0,q1: both lines released.
  - q2: sda_oe=1.
  - q3: scl_oe=1.
- BIT (4 ticks per bit, MSB first):
  - q0: scl_oe=1; sda_oe = ~bit.
  - q1: hold.
  - q2,q3: scl_oe=0.
  - After 8 bits -> ACK.
- ACK (4 ticks):
  - sda_oe=0 for the whole ACK slot.
  - SCL follows the same q pattern as BIT.
  - sda_i is sampled at the end of q3.
  - sda_i=0 (ACK): go to the next byte, or to STOP after byte 7.
  - sda_i=1 (NACK): record the byte index, go to STOP with an error flag.
- STOP (4 ticks):
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0.
  - q2,q3: sda_oe=0.
- FIN (1 cycle):
  - Pulse done, or nack_err if the error flag is set; never both.
  - cmd_ready=1 and busy=0 in the same cycle.
  - A new command may be accepted in that cycle.
- Timing:
  - A full success takes 4 + 8*9*4 + 4 = 296 ticks.
  - done asserts 296*CLK_DIV + 1 cycles after the accept edge.
  - NACK on byte k: nack_err asserts (4 + (k+1)*36 + 4)*CLK_DIV + 1 cycles after accept.
- SDA only changes while SCL is low, except the START/STOP edges.
- No clock stretching; SCL is never sampled.
- Back-to-back commands: each one gets its own START and STOP (no repeated start).

Test Plan:
- Reset mid-byte (rst at cycle 200 of a transfer, CLK_DIV=4) -> scl_oe=0, sda_oe=0 within the same cycle; cmd_ready=1, busy=0 after release; no done.
- Single write, CLK_DIV=4, addr 24'h012345, data 32'hDEADBEEF, responder always ACKs:
  - Decoded byte stream is A0 01 23 45 DE AD BE EF.
  - done pulses exactly 1185 cycles after accept; START and STOP conditions are legal.
- Responder NACKs the device byte (sda_i=1 in ACK slot 0) -> STOP issued, nack_err at cycle (4+36+4)*4+1=177, nack_byte=0, no done.
- NACK on byte 5 -> nack_err at cycle (4+216+4)*4+1=897, nack_byte=5, bytes 6..7 never driven.
- Back-to-back: cmd_valid held high with two commands -> second accepted in the FIN cycle of the first; two separate START/STOP pairs; two done pulses 1185 cycles apart.
- Protocol monitor across all runs -> SDA never changes while SCL is released, except at START/STOP; cmd inputs changed while busy have no effect.
